// File: rtl/control_pipe_if.sv
// Issue slot, memory handshake and per-stage control outputs of the control pipe.
interface control_pipe_if #(
  parameter int RAW = 4
);
  logic           in_valid;
  logic [3:0]     in_opcode;
  logic [RAW-1:0] in_rd;
  logic [RAW-1:0] in_ra;
  logic [RAW-1:0] in_rb;
  logic           issue_ready;
  logic           re_a;
  logic           re_b;
  logic           cmp_flag;
  logic           mem_ready;
  logic [1:0]     ex_sel_b;
  logic [3:0]     ex_alu_ctrl;
  logic           ex_cmp_en;
  logic           branch_taken;
  logic           mem_we;
  logic           mem_re;
  logic [1:0]     wb_sel_data;
  logic           wb_reg_we;
  logic [RAW-1:0] wb_rd;

  modport master (
    output in_valid, in_opcode, in_rd, in_ra, in_rb, cmp_flag, mem_ready,
    input  issue_ready, re_a, re_b, ex_sel_b, ex_alu_ctrl, ex_cmp_en,
           branch_taken, mem_we, mem_re, wb_sel_data, wb_reg_we, wb_rd
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_ra, in_rb, cmp_flag, mem_ready,
    output issue_ready, re_a, re_b, ex_sel_b, ex_alu_ctrl, ex_cmp_en,
           branch_taken, mem_we, mem_re, wb_sel_data, wb_reg_we, wb_rd
  );
endinterface

// File: rtl/control_pipe.sv
// Pipelined opcode decoder: decodes at issue and carries the control bundle
// through EX, MEM and WB with load-use stall, memory freeze and branch squash.
module control_pipe #(
  parameter int RAW         = 4,
  parameter int FLUSH_SLOTS = 2,
  parameter bit HAZARD_EN   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  control_pipe_if.slave bus
);

  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_CMP = 4'b1000;
  localparam logic [3:0] OP_MOV = 4'b1011;
  localparam logic [3:0] OP_LD  = 4'b1100;
  localparam logic [3:0] OP_ST  = 4'b1101;
  localparam logic [3:0] OP_BT  = 4'b1110;
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_SLOTS);

  typedef struct packed {
    logic [1:0]     sel_b;
    logic [3:0]     alu_ctrl;
    logic           cmp_en;
    logic           is_bt;
    logic           mem_we;
    logic           mem_re;
    logic [1:0]     sel_data;
    logic           reg_we;
    logic [RAW-1:0] rd;
  } ex_ctrl_t;

  typedef struct packed {
    logic           mem_we;
    logic           mem_re;
    logic [1:0]     sel_data;
    logic           reg_we;
    logic [RAW-1:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic [1:0]     sel_data;
    logic           reg_we;
    logic [RAW-1:0] rd;
  } wb_ctrl_t;

  ex_ctrl_t  dec;
  logic      dec_re_a;
  logic      dec_re_b;
  ex_ctrl_t  ex_b;
  mem_ctrl_t mem_b;
  wb_ctrl_t  wb_b;
  logic      ex_v, mem_v, wb_v;
  logic      ex_q, mem_q, wb_q;
  logic [2:0] squash_cnt;
  logic [2:0] cnt_eff;
  logic      squash_in;
  logic      freeze;
  logic      ld_hit;
  logic      loaduse;
  logic      accept;

  // Decode the issuing opcode into the EX bundle and the register read enables.
  always_comb begin
    dec      = '0;
    dec_re_a = 1'b1;
    dec_re_b = 1'b1;
    dec.rd   = bus.in_rd;
    if (!bus.in_opcode[3]) begin
      dec.alu_ctrl = bus.in_opcode;
      dec.reg_we   = 1'b1;
      if (bus.in_opcode == OP_NOT) dec_re_b = 1'b0;
    end else begin
      case (bus.in_opcode)
        OP_CMP: begin
          dec.alu_ctrl = 4'b0001;
          dec.cmp_en   = 1'b1;
        end
        OP_MOV: begin
          dec.sel_data = 2'd1;
          dec.reg_we   = 1'b1;
          dec_re_a     = 1'b0;
          dec_re_b     = 1'b0;
        end
        OP_LD: begin
          dec.sel_b    = 2'd1;
          dec.sel_data = 2'd2;
          dec.reg_we   = 1'b1;
          dec.mem_re   = 1'b1;
          dec_re_b     = 1'b0;
        end
        OP_ST: begin
          dec.sel_b  = 2'd2;
          dec.mem_we = 1'b1;
        end
        OP_BT: begin
          dec.is_bt = 1'b1;
          dec_re_a  = 1'b0;
          dec_re_b  = 1'b0;
        end
        default: begin
          dec_re_a = 1'b0;
          dec_re_b = 1'b0;
        end
      endcase
    end
  end

  assign ex_q  = ex_v  & ~rst;
  assign mem_q = mem_v & ~rst;
  assign wb_q  = wb_v  & ~rst;

  assign freeze  = mem_q & (mem_b.mem_we | mem_b.mem_re) & ~bus.mem_ready;
  assign ld_hit  = ex_q & ex_b.mem_re &
                   ((dec_re_a & (ex_b.rd == bus.in_ra)) | (dec_re_b & (ex_b.rd == bus.in_rb)));
  assign loaduse = HAZARD_EN & bus.in_valid & ld_hit;

  assign bus.branch_taken = ex_q & ex_b.is_bt & bus.cmp_flag & ~freeze;
  assign bus.issue_ready  = ~rst & ~freeze & ~loaduse;
  assign accept           = bus.in_valid & bus.issue_ready;

  // A taken branch squashes the instruction accepted on its own edge as well.
  assign cnt_eff   = bus.branch_taken ? FLUSH_LOAD : squash_cnt;
  assign squash_in = cnt_eff != 3'd0;

  // Stage valid bits and squash counter; a freeze holds everything in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v       <= 1'b0;
      mem_v      <= 1'b0;
      wb_v       <= 1'b0;
      squash_cnt <= 3'd0;
    end else if (!freeze) begin
      ex_v       <= accept & ~squash_in;
      mem_v      <= ex_v;
      wb_v       <= mem_v;
      squash_cnt <= (accept && squash_in) ? cnt_eff - 3'd1 : cnt_eff;
    end
  end

  // Control bundles shift alongside the valid bits; outputs are valid-qualified.
  always_ff @(posedge clk) begin
    if (!freeze) begin
      ex_b  <= dec;
      mem_b <= '{ex_b.mem_we, ex_b.mem_re, ex_b.sel_data, ex_b.reg_we, ex_b.rd};
      wb_b  <= '{mem_b.sel_data, mem_b.reg_we, mem_b.rd};
    end
  end

  assign bus.re_a        = dec_re_a;
  assign bus.re_b        = dec_re_b;
  assign bus.ex_sel_b    = ex_b.sel_b & {2{ex_q}};
  assign bus.ex_alu_ctrl = ex_b.alu_ctrl & {4{ex_q}};
  assign bus.ex_cmp_en   = ex_b.cmp_en & ex_q;
  assign bus.mem_we      = mem_b.mem_we & mem_q;
  assign bus.mem_re      = mem_b.mem_re & mem_q;
  assign bus.wb_sel_data = wb_b.sel_data & {2{wb_q}};
  assign bus.wb_reg_we   = wb_b.reg_we & wb_q;
  assign bus.wb_rd       = wb_b.rd & {RAW{wb_q}};

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: directed scenarios with literal expectations plus a
// randomized run checked every cycle against an instruction-slot model.
module tb_control_pipe;

  localparam int RAW   = 4;
  localparam int FLUSH = 2;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_CMP = 4'b1000;
  localparam logic [3:0] OP_MOV = 4'b1011;
  localparam logic [3:0] OP_LD  = 4'b1100;
  localparam logic [3:0] OP_ST  = 4'b1101;
  localparam logic [3:0] OP_BT  = 4'b1110;
  localparam logic [3:0] OP_NOP = 4'b1111;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [3:0]     in_opcode;
  logic [RAW-1:0] in_rd, in_ra, in_rb;
  logic           cmp_flag;
  logic           mem_ready;

  int checks = 0;
  int errors = 0;

  control_pipe_if #(.RAW(RAW)) bus0 ();
  control_pipe_if #(.RAW(RAW)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_opcode = in_opcode;
  assign bus0.in_rd     = in_rd;
  assign bus0.in_ra     = in_ra;
  assign bus0.in_rb     = in_rb;
  assign bus0.cmp_flag  = cmp_flag;
  assign bus0.mem_ready = mem_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_opcode = in_opcode;
  assign bus1.in_rd     = in_rd;
  assign bus1.in_ra     = in_ra;
  assign bus1.in_rb     = in_rb;
  assign bus1.cmp_flag  = cmp_flag;
  assign bus1.mem_ready = mem_ready;

  control_pipe #(.RAW(RAW), .FLUSH_SLOTS(FLUSH), .HAZARD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  control_pipe #(.RAW(RAW), .FLUSH_SLOTS(FLUSH), .HAZARD_EN(1'b0)) dut_nohaz (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [3:0] op, input int rd, input int ra,
                               input int rb, input bit cf, input bit mr, input bit r);
    @(posedge clk);
    #1;
    rst       = r;
    in_valid  = v;
    in_opcode = op;
    in_rd     = RAW'(rd);
    in_ra     = RAW'(ra);
    in_rb     = RAW'(rb);
    cmp_flag  = cf;
    mem_ready = mr;
  endtask

  task automatic idleCycle(input bit mr);
    applyStimulus(1'b0, OP_NOP, 0, 0, 0, 1'b0, mr, 1'b0);
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [3:0] m_alu(input logic [3:0] op);
    if (op < 4'd8)   return op;
    if (op == OP_CMP) return 4'b0001;
    return 4'b0000;
  endfunction

  function automatic logic [1:0] m_selb(input logic [3:0] op);
    if (op == OP_LD) return 2'd1;
    if (op == OP_ST) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [1:0] m_seldata(input logic [3:0] op);
    if (op == OP_MOV) return 2'd1;
    if (op == OP_LD)  return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit m_is_nop(input logic [3:0] op);
    return (op == 4'b1001) || (op == 4'b1010) || (op == OP_NOP);
  endfunction

  function automatic bit m_we(input logic [3:0] op);
    return (op < 4'd8) || (op == OP_MOV) || (op == OP_LD);
  endfunction

  function automatic bit m_rea(input logic [3:0] op);
    return !((op == OP_MOV) || (op == OP_BT) || m_is_nop(op));
  endfunction

  function automatic bit m_reb(input logic [3:0] op);
    return ((op < 4'd8) && (op != OP_NOT)) || (op == OP_CMP) || (op == OP_ST);
  endfunction

  typedef struct {
    bit             v;
    logic [3:0]     op;
    logic [RAW-1:0] rd;
  } slot_t;

  slot_t stg [3];
  int    squash_left = 0;

  // Compare every output each cycle, then advance the model to the next edge.
  always @(negedge clk) begin : model_cmp
    bit frz, lu, bt, ir, acc, sq, ev, mv, wv;
    logic [3:0] iop;
    iop = in_opcode;
    ev  = stg[0].v && !rst;
    mv  = stg[1].v && !rst;
    wv  = stg[2].v && !rst;
    frz = mv && (stg[1].op == OP_LD || stg[1].op == OP_ST) && !mem_ready;
    lu  = !rst && in_valid && ev && stg[0].op == OP_LD &&
          ((m_rea(iop) && stg[0].rd == in_ra) || (m_reb(iop) && stg[0].rd == in_rb));
    bt  = ev && stg[0].op == OP_BT && cmp_flag && !frz;
    ir  = !rst && !frz && !lu;

    checkOutput("m_issue_ready",  bus0.issue_ready,  ir);
    checkOutput("m_re_a",         bus0.re_a,         m_rea(iop));
    checkOutput("m_re_b",         bus0.re_b,         m_reb(iop));
    checkOutput("m_ex_sel_b",     bus0.ex_sel_b,     ev ? m_selb(stg[0].op) : 2'd0);
    checkOutput("m_ex_alu_ctrl",  bus0.ex_alu_ctrl,  ev ? m_alu(stg[0].op) : 4'd0);
    checkOutput("m_ex_cmp_en",    bus0.ex_cmp_en,    ev && stg[0].op == OP_CMP);
    checkOutput("m_branch_taken", bus0.branch_taken, bt);
    checkOutput("m_mem_we",       bus0.mem_we,       mv && stg[1].op == OP_ST);
    checkOutput("m_mem_re",       bus0.mem_re,       mv && stg[1].op == OP_LD);
    checkOutput("m_wb_sel_data",  bus0.wb_sel_data,  wv ? m_seldata(stg[2].op) : 2'd0);
    checkOutput("m_wb_reg_we",    bus0.wb_reg_we,    wv && m_we(stg[2].op));
    checkOutput("m_wb_rd",        bus0.wb_rd,        wv ? stg[2].rd : '0);

    if (rst) begin
      for (int i = 0; i < 3; i++) stg[i].v = 1'b0;
      squash_left = 0;
    end else if (!frz) begin
      stg[2] = stg[1];
      stg[1] = stg[0];
      acc    = in_valid && ir;
      if (bt) squash_left = FLUSH;
      sq = 1'b0;
      if (acc && squash_left > 0) begin
        sq = 1'b1;
        squash_left--;
      end
      stg[0].v  = acc && !sq;
      stg[0].op = iop;
      stg[0].rd = in_rd;
    end
  end

  // ---------------- directed scenarios and random run ----------------
  initial begin : main
    int mem_we_cnt;
    int wb_we_cnt;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_opcode = OP_NOP;
    in_rd     = '0;
    in_ra     = '0;
    in_rb     = '0;
    cmp_flag  = 1'b0;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_issue_ready", bus0.issue_ready, 0);
    checkOutput("rst_wb_reg_we",   bus0.wb_reg_we,   0);
    checkOutput("rst_mem_we",      bus0.mem_we,      0);
    checkOutput("rst_branch",      bus0.branch_taken, 0);

    $display("[TB] ALU issue and latency");
    applyStimulus(1'b1, OP_ADD, 3, 1, 2, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("add_issue_ready", bus0.issue_ready, 1);
    checkOutput("add_re_a", bus0.re_a, 1);
    applyStimulus(1'b1, 4'b0101, 4, 0, 1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("add_ex_alu", bus0.ex_alu_ctrl, 0);
    checkOutput("add_wb_early", bus0.wb_reg_we, 0);
    idleCycle(1'b1);
    @(negedge clk);
    checkOutput("op5_ex_alu", bus0.ex_alu_ctrl, 5);
    checkOutput("add_wb_early2", bus0.wb_reg_we, 0);
    idleCycle(1'b1);
    @(negedge clk);
    checkOutput("add_wb_we", bus0.wb_reg_we, 1);
    checkOutput("add_wb_rd", bus0.wb_rd, 3);
    checkOutput("add_wb_sel", bus0.wb_sel_data, 0);
    idleCycle(1'b1);
    @(negedge clk);
    checkOutput("op5_wb_rd", bus0.wb_rd, 4);
    idleCycle(1'b1);
    @(negedge clk);
    checkOutput("idle_wb_we", bus0.wb_reg_we, 0);

    $display("[TB] store with memory freeze");
    applyStimulus(1'b1, OP_ST, 1, 2, 3, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("st_re_b", bus0.re_b, 1);
    idleCycle(1'b1);
    @(negedge clk);
    checkOutput("st_ex_sel_b", bus0.ex_sel_b, 2);
    mem_we_cnt = 0;
    wb_we_cnt  = 0;
    for (int i = 0; i < 4; i++) begin
      idleCycle(1'b0);
      @(negedge clk);
      checkOutput("freeze_issue_ready", bus0.issue_ready, 0);
      mem_we_cnt += int'(bus0.mem_we);
      wb_we_cnt  += int'(bus0.wb_reg_we);
    end
    for (int i = 0; i < 4; i++) begin
      idleCycle(1'b1);
      @(negedge clk);
      if (i == 0) checkOutput("unfreeze_issue_ready", bus0.issue_ready, 1);
      mem_we_cnt += int'(bus0.mem_we);
      wb_we_cnt  += int'(bus0.wb_reg_we);
    end
    checkOutput("st_mem_we_cycles", mem_we_cnt, 5);
    checkOutput("st_wb_writes", wb_we_cnt, 0);

    $display("[TB] load-use stall");
    applyStimulus(1'b1, OP_LD, 5, 1, 2, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_ADD, 7, 5, 0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("lu_stall", bus0.issue_ready, 0);
    checkOutput("lu_nohaz_ready", bus1.issue_ready, 1);
    applyStimulus(1'b1, OP_ADD, 7, 5, 0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("lu_release", bus0.issue_ready, 1);
    idleCycle(1'b1);
    @(negedge clk);
    checkOutput("ld_wb_rd", bus0.wb_rd, 5);
    checkOutput("ld_wb_sel", bus0.wb_sel_data, 2);
    checkOutput("nohaz_ld_wb_rd", bus1.wb_rd, 5);
    idleCycle(1'b1);
    @(negedge clk);
    checkOutput("lu_bubble_wb", bus0.wb_reg_we, 0);
    checkOutput("nohaz_add_wb_rd", bus1.wb_rd, 7);
    idleCycle(1'b1);
    @(negedge clk);
    checkOutput("lu_add_wb_we", bus0.wb_reg_we, 1);
    checkOutput("lu_add_wb_rd", bus0.wb_rd, 7);

    $display("[TB] taken branch squash");
    applyStimulus(1'b1, OP_BT, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_MOV, 8, 0, 0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bt_taken", bus0.branch_taken, 1);
    applyStimulus(1'b1, OP_NOT, 9, 1, 0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bt_pulse_end", bus0.branch_taken, 0);
    applyStimulus(1'b1, OP_ADD, 10, 1, 2, 1'b0, 1'b1, 1'b0);
    idleCycle(1'b1);
    @(negedge clk);
    checkOutput("squash_mov_wb", bus0.wb_reg_we, 0);
    idleCycle(1'b1);
    @(negedge clk);
    checkOutput("squash_not_wb", bus0.wb_reg_we, 0);
    idleCycle(1'b1);
    @(negedge clk);
    checkOutput("post_squash_wb_we", bus0.wb_reg_we, 1);
    checkOutput("post_squash_wb_rd", bus0.wb_rd, 10);

    $display("[TB] branch not taken");
    applyStimulus(1'b1, OP_BT, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_MOV, 11, 0, 0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bt_not_taken", bus0.branch_taken, 0);
    idleCycle(1'b1);
    idleCycle(1'b1);
    idleCycle(1'b1);
    @(negedge clk);
    checkOutput("mov_wb_we", bus0.wb_reg_we, 1);
    checkOutput("mov_wb_rd", bus0.wb_rd, 11);
    checkOutput("mov_wb_sel", bus0.wb_sel_data, 1);

    $display("[TB] reset during freeze");
    applyStimulus(1'b1, OP_LD, 2, 0, 0, 1'b0, 1'b1, 1'b0);
    idleCycle(1'b1);
    idleCycle(1'b0);
    @(negedge clk);
    checkOutput("frz_mem_re", bus0.mem_re, 1);
    checkOutput("frz_issue_ready", bus0.issue_ready, 0);
    applyStimulus(1'b0, OP_NOP, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("rst_frz_mem_re", bus0.mem_re, 0);
    checkOutput("rst_frz_issue_ready", bus0.issue_ready, 0);
    idleCycle(1'b0);
    @(negedge clk);
    checkOutput("post_rst_mem_re", bus0.mem_re, 0);
    checkOutput("post_rst_issue_ready", bus0.issue_ready, 1);
    checkOutput("post_rst_wb_we", bus0.wb_reg_we, 0);

    $display("[TB] randomized run");
    for (int n = 0; n < 2500; n++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)),
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 99) == 0);
    end
    idleCycle(1'b1);
    repeat (4) idleCycle(1'b1);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_pipe.md
Name: control_pipe

Overview:
- Pipelined successor to the filter-processor combinational opcode decoder.
- Decodes the 4-bit opcode at issue into the same control bundle: sel_B, ALU control, memory enables, WB select, reg_WE, RE_A/RE_B, cmp_EN, branch.
- Carries the bundle through registered EX, MEM and WB stages and aligns each field with its consuming stage.
- Adds load-use stall, memory-handshake freeze and taken-branch squash.

Parameters:
- RAW, 4, register-address width for rd/ra/rb.
- FLUSH_SLOTS, 2, number of accepted instructions squashed after a taken branch (1..7).
- HAZARD_EN, 1, 1 enables load-use stall detection; 0 disables it (software-scheduled).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  issue slot holds an instruction
- in_opcode  in  4  opcode of issued instruction
- in_rd  in  RAW  destination register
- in_ra  in  RAW  source A
- in_rb  in  RAW  source B
- issue_ready  out  1  instruction accepted this cycle when in_valid&issue_ready
- re_a  out  1  combinational register-file read enable A for in_opcode
- re_b  out  1  combinational register-file read enable B for in_opcode
- cmp_flag  in  1  compare result, valid while BT is in EX
- mem_ready  in  1  memory completes the LD/ST held in MEM this cycle
- ex_sel_b  out  2  operand-B select for instruction in EX
- ex_alu_ctrl  out  4  ALU operation in EX
- ex_cmp_en  out  1  CMP in EX
- branch_taken  out  1  one-cycle pulse: BT in EX and cmp_flag=1
- mem_we  out  1  ST in MEM
- mem_re  out  1  LD in MEM
- wb_sel_data  out  2  WB source: 0 ALU, 1 immediate, 2 load
- wb_reg_we  out  1  register write in WB
- wb_rd  out  RAW  destination register in WB

Behaviour:
- Opcode map:
  - 0000-0111 ALU ops, 0110 = NOT.
  - 1000 CMP, 1011 MOV, 1100 LD, 1101 ST, 1110 BT, 1111 NOP.
  - Unlisted opcodes 1001/1010 decode as NOP.
- Decode rules:
  - alu_ctrl = opcode for 0xxx; 0001 for CMP; 0000 for LD/ST.
  - sel_B = 1 for LD, 2 for ST, else 0.
  - sel_data = 1 for MOV, 2 for LD, else 0.
  - reg_we = 0 for CMP, ST, BT, NOP.
  - re_a = 0 for MOV, BT, NOP.
  - re_b = 0 for NOT, MOV, LD, BT, NOP.
- Stage registers:
  - EX, MEM and WB each hold a valid bit plus its bundle.
  - All qualified outputs are field & stage_valid.
  - Accept → EX next edge, MEM +1, WB +2. Latency from accept to wb_reg_we is 3 cycles with no stalls.
- Freeze:
  - Condition: MEM valid, op is LD or ST, and mem_ready=0.
  - All three stages hold; issue_ready=0; mem_we/mem_re stay asserted.
  - The first edge with mem_ready=1 advances the pipe.
- Load-use stall (HAZARD_EN=1):
  - Condition: EX holds LD with rd matching in_ra (with re_a=1) or in_rb (with re_b=1), and in_valid=1.
  - issue_ready=0; a bubble enters EX; older stages advance.
  - Stall lasts exactly 1 cycle unless a freeze overlaps it.
- Branch:
  - branch_taken = EX valid & BT & cmp_flag & ~freeze. Asserted for one cycle only.
  - The same edge loads the squash counter with FLUSH_SLOTS.
  - While the counter is nonzero, each accepted instruction enters EX as a bubble and decrements the counter.
  - A branch resolving while the counter is nonzero reloads it.
  - Squashed instructions never produce mem_we, reg_we, cmp_en or branch_taken.
- Simultaneous events:
  - Freeze dominates load-use stall and branch: nothing advances and no pulse.
  - A load-use stall in the same cycle as a taken branch inserts the bubble and still loads the counter.
- issue_ready = ~rst & ~freeze & ~loaduse.
- Reset:
  - All valid bits = 0, squash counter = 0.
  - All registered outputs read 0; issue_ready = 0 while rst=1.
  - Reset mid-freeze or mid-squash abandons everything; the first cycle after reset accepts normally.

Test Plan:
- Reset then issue ADD(0000, rd=3) → ex_alu_ctrl=0000 at +1; wb_reg_we=1, wb_rd=3, wb_sel_data=0 at +3; all outputs 0 during rst.
- Issue ST(1101) with mem_ready low for 4 cycles → mem_we=1 for 5 cycles; issue_ready=0 for 4 cycles; WB never writes.
- Issue LD rd=5, then ADD ra=5 → issue_ready=0 for 1 cycle; one bubble; ADD reaches WB 4 cycles after its first presentation. With HAZARD_EN=0, no stall.
- Issue BT with cmp_flag=1, followed by MOV and NOT (FLUSH_SLOTS=2) → branch_taken pulse at BT's EX cycle; MOV and NOT produce no wb_reg_we; the third instruction retires normally.
- Issue BT with cmp_flag=0 → no branch_taken; following instructions retire.
- Assert rst while LD is frozen in MEM → next cycle mem_re=0, all valid bits 0, issue_ready=1.
